// File: rtl/usb_sniffer_burst_ctrl.sv
// Burst write scheduler: drains the capture FIFO into a circular/one-shot buffer with aligned AXI4 INCR bursts.
// Optional macro USB_SNIFFER_FLUSH_TIMEOUT_EN flushes partial bursts after TIMEOUT idle cycles.
module usb_sniffer_burst_ctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned LEVEL_W   = 11,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        cfg_base_i,
  input  logic [31:0]        cfg_end_i,
  input  logic               cfg_reset_i,
  input  logic               cfg_cont_i,
  input  logic [LEVEL_W-1:0] fifo_level_i,
  input  logic [31:0]        fifo_data_i,
  output logic               fifo_pop_o,
  output logic               axi_awvalid_o,
  input  logic               axi_awready_i,
  output logic [31:0]        axi_awaddr_o,
  output logic [7:0]         axi_awlen_o,
  output logic [1:0]         axi_awburst_o,
  output logic [3:0]         axi_awid_o,
  output logic               axi_wvalid_o,
  input  logic               axi_wready_i,
  output logic [31:0]        axi_wdata_o,
  output logic [3:0]         axi_wstrb_o,
  output logic               axi_wlast_o,
  input  logic               axi_bvalid_i,
  output logic               axi_bready_o,
  input  logic [1:0]         axi_bresp_i,
  output logic [31:0]        status_current_o,
  output logic               status_wrapped_o,
  output logic               status_full_o,
  output logic               status_err_o,
  output logic               busy_o
);

  localparam int unsigned OFF_MASK = BURST_LEN - 1;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 2);
`ifdef USB_SNIFFER_FLUSH_TIMEOUT_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_cur;
  logic [31:0]      r_awaddr;
  logic [7:0]       r_awlen;
  logic [7:0]       r_n;
  logic [7:0]       r_beat;
  logic             r_awvalid;
  logic             r_wvalid;
  logic             r_wlast;
  logic             r_bready;
  logic             r_wrapped;
  logic             r_full;
  logic             r_err;
  logic             r_pend;
  logic             r_cont;
  logic             r_hit_end;
  logic [CNT_W-1:0] r_idle_cnt;

  logic [31:0] w_off;
  logic [31:0] w_room;
  logic [31:0] w_level;
  logic [31:0] w_n;
  logic        w_idle_cond;
  logic        w_flush;
  logic        w_start;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;

  // Burst sizing: never cross a BURST_LEN*4 boundary from the current write pointer.
  assign w_off       = (r_wr_addr >> 2) & 32'(OFF_MASK);
  assign w_room      = 32'(BURST_LEN) - w_off;
  assign w_level     = 32'(fifo_level_i);
  assign w_n         = (w_level < w_room) ? w_level : w_room;
  assign w_idle_cond = (w_level != 32'd0) && (w_level < w_room);
  assign w_flush     = FLUSH_EN && (r_idle_cnt >= CNT_W'(TIMEOUT)) && (w_level != 32'd0);
  assign w_start     = (r_state == S_IDLE) && !cfg_reset_i && !r_full && (w_n != 32'd0) &&
                       ((w_level >= w_room) || w_flush);

  assign w_aw_hs = r_awvalid & axi_awready_i;
  assign w_w_hs  = r_wvalid & axi_wready_i;
  assign w_b_hs  = r_bready & axi_bvalid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_AW;
      S_AW:    if (w_aw_hs) w_state_nxt = S_W;
      S_W:     if (w_w_hs && r_wlast) w_state_nxt = S_B;
      S_B:     if (w_b_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst datapath, pointers and sticky status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_addr <= '0;
      r_cur     <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_n       <= '0;
      r_beat    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_wrapped <= 1'b0;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
      r_pend    <= 1'b0;
      r_cont    <= 1'b0;
      r_hit_end <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_reset_i) begin
            r_wr_addr <= cfg_base_i;
            r_cur     <= cfg_base_i;
            r_wrapped <= 1'b0;
            r_full    <= 1'b0;
            r_err     <= 1'b0;
          end else if (w_start) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= r_wr_addr;
            r_awlen   <= 8'(w_n - 32'd1);
            r_n       <= 8'(w_n);
            r_cont    <= cfg_cont_i;
            r_hit_end <= 1'b0;
          end
        end
        S_AW: begin
          if (cfg_reset_i) r_pend <= 1'b1;
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (r_n == 8'd1);
            r_beat    <= '0;
          end
        end
        S_W: begin
          if (cfg_reset_i) r_pend <= 1'b1;
          if (w_w_hs) begin
            if (r_wr_addr == cfg_end_i) begin
              r_wr_addr <= cfg_base_i;
              r_hit_end <= 1'b1;
            end else begin
              r_wr_addr <= r_wr_addr + 32'd4;
            end
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_wlast <= (8'(r_beat + 8'd2) == r_n);
            end
          end
        end
        S_B: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_pend   <= 1'b0;
            // A reset requested during the burst replaces the status update.
            if (r_pend || cfg_reset_i) begin
              r_wr_addr <= cfg_base_i;
              r_cur     <= cfg_base_i;
              r_wrapped <= 1'b0;
              r_full    <= 1'b0;
              r_err     <= 1'b0;
            end else begin
              r_cur <= r_hit_end ? cfg_base_i : (r_cur + {22'd0, r_n, 2'b00});
              if (r_hit_end && r_cont)  r_wrapped <= 1'b1;
              if (r_hit_end && !r_cont) r_full    <= 1'b1;
              if (axi_bresp_i != 2'b00) r_err     <= 1'b1;
            end
          end else if (cfg_reset_i) begin
            r_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Idle counter for partial-burst flushing; held at zero when the feature is off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt <= '0;
    end else if (FLUSH_EN && (r_state == S_IDLE) && w_idle_cond) begin
      if (r_idle_cnt < CNT_W'(TIMEOUT)) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end

  assign fifo_pop_o       = r_wvalid & axi_wready_i;
  assign axi_awvalid_o    = r_awvalid;
  assign axi_awaddr_o     = r_awaddr;
  assign axi_awlen_o      = r_awlen;
  assign axi_awburst_o    = 2'b01;
  assign axi_awid_o       = 4'd0;
  assign axi_wvalid_o     = r_wvalid;
  assign axi_wdata_o      = fifo_data_i;
  assign axi_wstrb_o      = 4'hF;
  assign axi_wlast_o      = r_wlast;
  assign axi_bready_o     = r_bready;
  assign status_current_o = r_cur;
  assign status_wrapped_o = r_wrapped;
  assign status_full_o    = r_full;
  assign status_err_o     = r_err;
  assign busy_o           = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_sniffer_burst_ctrl.sv
// Bench for usb_sniffer_burst_ctrl: FWFT FIFO + AXI slave stimulus, buffer-level reference model, directed checks.
module tb_usb_sniffer_burst_ctrl;
  localparam int unsigned BL = 16;
  localparam int unsigned LW = 11;
  localparam int unsigned TO = 255;
`ifdef USB_SNIFFER_FLUSH_TIMEOUT_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic [31:0]   cfg_base_i, cfg_end_i;
  logic          cfg_reset_i, cfg_cont_i;
  logic [LW-1:0] fifo_level_i;
  logic [31:0]   fifo_data_i;
  logic          fifo_pop_o;
  logic          axi_awvalid_o, axi_awready_i;
  logic [31:0]   axi_awaddr_o;
  logic [7:0]    axi_awlen_o;
  logic [1:0]    axi_awburst_o;
  logic [3:0]    axi_awid_o;
  logic          axi_wvalid_o, axi_wready_i;
  logic [31:0]   axi_wdata_o;
  logic [3:0]    axi_wstrb_o;
  logic          axi_wlast_o;
  logic          axi_bvalid_i, axi_bready_o;
  logic [1:0]    axi_bresp_i;
  logic [31:0]   status_current_o;
  logic          status_wrapped_o, status_full_o, status_err_o, busy_o;

  usb_sniffer_burst_ctrl #(.BURST_LEN(BL), .LEVEL_W(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_base_i(cfg_base_i), .cfg_end_i(cfg_end_i), .cfg_reset_i(cfg_reset_i), .cfg_cont_i(cfg_cont_i),
    .fifo_level_i(fifo_level_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awid_o(axi_awid_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
    .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
    .status_current_o(status_current_o), .status_wrapped_o(status_wrapped_o),
    .status_full_o(status_full_o), .status_err_o(status_err_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO contents and slave controls
  logic [31:0] q[$];
  int          push_req = 0;
  logic [31:0] next_push_word = 32'hA500_0000;
  int          aw_stall = 0;
  bit          wr_rand = 1'b0;
  logic [1:0]  bresp_next = 2'b00;
  bit          f_pop = 1'b0, f_last = 1'b0, f_bhs = 1'b0;
  int          s_aw_cnt = 0;
  bit          mon_en = 1'b0;

  // Buffer-level reference model
  logic [31:0] m_wr = 32'h0, m_cur = 32'h0, m_aw_addr = 32'h0, m_next_word = 32'hA500_0000;
  logic [7:0]  m_aw_len = 8'h0;
  int          m_n = 0, m_beats = 0, m_idle = 0;
  bit          m_wrapped = 0, m_full = 0, m_err = 0, m_pend = 0;
  bit          m_active = 0, m_aw_exp = 0, m_aw_done = 0, m_hit = 0, m_cont = 0;
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  int          b_count = 0;

  // FIFO and AXI slave: update inputs just after each rising edge
  always begin
    logic [31:0] tmp;
    @(posedge clk_i);
    #1;
    if (f_pop && q.size() > 0) tmp = q.pop_front();
    for (int i = 0; i < push_req; i++) begin
      q.push_back(next_push_word);
      next_push_word = next_push_word + 32'd1;
    end
    push_req = 0;
    fifo_level_i  = LW'(q.size());
    fifo_data_i   = (q.size() > 0) ? q[0] : 32'h0;
    axi_awready_i = (s_aw_cnt >= aw_stall);
    axi_wready_i  = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (f_bhs) axi_bvalid_i = 1'b0;
    if (f_last) begin
      axi_bvalid_i = 1'b1;
      axi_bresp_i  = bresp_next;
    end
  end

  task automatic reload();
    m_wr = cfg_base_i; m_cur = cfg_base_i;
    m_wrapped = 0; m_full = 0; m_err = 0;
  endtask

  // Compare process: every falling edge, check outputs then advance the model
  always @(negedge clk_i) begin
    int room, lvl, n;
    bit due;
    logic [31:0] t;
    if (mon_en) begin
      chk("current", status_current_o, m_cur);
      chk("wrapped", 32'(status_wrapped_o), 32'(m_wrapped));
      chk("full", 32'(status_full_o), 32'(m_full));
      chk("err", 32'(status_err_o), 32'(m_err));
      chk("pop", 32'(fifo_pop_o), 32'(axi_wvalid_o & axi_wready_i));

      if (m_aw_exp) begin
        chk("aw_start", 32'(axi_awvalid_o), 32'd1);
        chk("aw_addr", axi_awaddr_o, m_aw_addr);
        chk("aw_len", 32'(axi_awlen_o), 32'(m_aw_len));
        m_aw_exp = 0; m_active = 1; m_aw_done = 0;
      end else if (!m_active) begin
        chk("aw_idle", 32'(axi_awvalid_o), 32'd0);
      end else if (axi_awvalid_o) begin
        chk("aw_addr_hold", axi_awaddr_o, m_aw_addr);
        chk("aw_len_hold", 32'(axi_awlen_o), 32'(m_aw_len));
      end

      if (!m_active) begin
        room = BL - ((m_wr >> 2) % BL);
        lvl  = int'(fifo_level_i);
        due  = FLUSH && (m_idle >= TO);
        if (lvl > 0 && lvl < room) begin
          if (m_idle < TO) m_idle++;
        end else m_idle = 0;
        if (cfg_reset_i) reload();
        else if (!m_full && (lvl >= room || (due && lvl > 0))) begin
          n = (lvl < room) ? lvl : room;
          m_aw_exp = 1; m_aw_addr = m_wr; m_aw_len = 8'(n - 1); m_n = n;
          m_cont = cfg_cont_i; m_beats = 0; m_hit = 0;
        end
      end else begin
        m_idle = 0;
        if (cfg_reset_i && !(axi_bvalid_i && axi_bready_o)) m_pend = 1;
      end

      if (axi_wvalid_o && axi_wready_i) begin
        chk("w_after_aw", 32'(m_aw_done), 32'd1);
        chk("w_in_burst", 32'(m_beats < m_n), 32'd1);
        chk("wdata", axi_wdata_o, m_next_word);
        chk("wlast", 32'(axi_wlast_o), 32'(m_beats == m_n - 1));
        chk("wstrb", 32'(axi_wstrb_o), 32'hF);
        if (m_wr == cfg_end_i) begin m_hit = 1; m_wr = cfg_base_i; end
        else m_wr = m_wr + 32'd4;
        m_beats++;
        m_next_word = m_next_word + 32'd1;
      end

      if (axi_awvalid_o && axi_awready_i) begin
        chk("awburst", 32'(axi_awburst_o), 32'd1);
        chk("awid", 32'(axi_awid_o), 32'd0);
        aw_addr_log.push_back(axi_awaddr_o);
        aw_len_log.push_back(axi_awlen_o);
        m_aw_done = 1;
      end

      if (axi_bvalid_i && axi_bready_o) begin
        chk("beats_per_burst", 32'(m_beats), 32'(m_n));
        if (m_pend || cfg_reset_i) reload();
        else begin
          t = m_cur + 32'(4 * m_n);
          if (t > cfg_end_i) t = cfg_base_i + (t - cfg_end_i - 32'd4);
          m_cur = t;
          if (m_hit && m_cont)  m_wrapped = 1;
          if (m_hit && !m_cont) m_full = 1;
          if (axi_bresp_i != 2'b00) m_err = 1;
        end
        m_pend = 0; m_active = 0;
        b_count++;
      end

      if (axi_awvalid_o && axi_awready_i) s_aw_cnt = 0;
      else if (axi_awvalid_o) s_aw_cnt++;
      else s_aw_cnt = 0;
      f_pop  = fifo_pop_o;
      f_last = axi_wvalid_o && axi_wready_i && axi_wlast_o;
      f_bhs  = axi_bvalid_i && axi_bready_o;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic push(input int n);
    @(posedge clk_i); #2;
    push_req += n;
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #2 cfg_reset_i = 1'b1;
    @(posedge clk_i); #2 cfg_reset_i = 1'b0;
  endtask

  task automatic wait_b(input int target, input int budget);
    int k = 0;
    while (b_count < target && k < budget) begin cyc(1); k++; end
    chk("b_wait", 32'(b_count), 32'(target));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_ni = 1'b0; cfg_base_i = 32'h0; cfg_end_i = 32'h0; cfg_reset_i = 1'b0; cfg_cont_i = 1'b0;
    fifo_level_i = '0; fifo_data_i = 32'h0; axi_awready_i = 1'b0; axi_wready_i = 1'b0;
    axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    mon_en = 1'b1;
    cyc(1);
    chk("rst_awvalid", 32'(axi_awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(axi_wvalid_o), 32'd0);
    chk("rst_bready", 32'(axi_bready_o), 32'd0);
    chk("rst_awaddr", axi_awaddr_o, 32'h0);
    chk("rst_awlen", 32'(axi_awlen_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // One-shot window 0x1000..0x10FC, 40 words
    @(posedge clk_i); #2 cfg_base_i = 32'h1000; cfg_end_i = 32'h10FC; cfg_cont_i = 1'b0;
    pulse_reset();
    push(40);
    wait_b(2, 300);
    cyc(3);
    chk("s1_aw0_addr", aw_addr_log[0], 32'h1000);
    chk("s1_aw0_len", 32'(aw_len_log[0]), 32'd15);
    chk("s1_aw1_addr", aw_addr_log[1], 32'h1040);
    chk("s1_current", status_current_o, 32'h1080);
    chk("s1_level", 32'(fifo_level_i), 32'd8);
    chk("s1_busy", 32'(busy_o), 32'd0);

    // Fill to 64 words total: buffer full, no further bursts
    push(24);
    wait_b(4, 300);
    cyc(3);
    chk("s2_full", 32'(status_full_o), 32'd1);
    chk("s2_current", status_current_o, 32'h1000);
    push(21);
    cyc(40);
    chk("s2_no_5th_aw", 32'(aw_addr_log.size()), 32'd4);
    chk("s2_level", 32'(fifo_level_i), 32'd21);

    // Circular: 80 words from base
    @(posedge clk_i); #2 cfg_cont_i = 1'b1;
    pulse_reset();
    wait_b(5, 300);
    push(59);
    wait_b(8, 400);
    cyc(2);
    chk("s3_wrapped", 32'(status_wrapped_o), 32'd1);
    chk("s3_full", 32'(status_full_o), 32'd0);
    chk("s3_current", status_current_o, 32'h1000);
    wait_b(9, 300);
    cyc(3);
    chk("s3_aw5_addr", aw_addr_log[8], 32'h1000);
    chk("s3_current2", status_current_o, 32'h1040);

    // Error response under AW/W backpressure
    @(posedge clk_i); #2 aw_stall = 20; wr_rand = 1'b1; bresp_next = 2'b10;
    push(16);
    wait_b(10, 600);
    cyc(3);
    chk("s4_err", 32'(status_err_o), 32'd1);
    chk("s4_current", status_current_o, 32'h1080);
    chk("s4_aw_addr", aw_addr_log[9], 32'h1040);
    chk("s4_aw_len", 32'(aw_len_log[9]), 32'd15);
    @(posedge clk_i); #2 bresp_next = 2'b00;

    // Reset requested mid-W: burst finishes, then pointers reload
    push(16);
    k = 0;
    while (!(m_active && m_beats >= 3) && k < 400) begin cyc(1); k++; end
    chk("s5_mid_w", 32'(m_beats >= 3), 32'd1);
    pulse_reset();
    wait_b(11, 600);
    cyc(3);
    chk("s5_current", status_current_o, 32'h1000);
    chk("s5_err", 32'(status_err_o), 32'd0);
    chk("s5_wrapped", 32'(status_wrapped_o), 32'd0);
    @(posedge clk_i); #2 aw_stall = 0; wr_rand = 1'b0;
    push(16);
    wait_b(12, 300);
    cyc(3);
    chk("s5_aw_addr", aw_addr_log[11], 32'h1000);
    chk("s5_current2", status_current_o, 32'h1040);

    // Sparse traffic: 3 words then idle
    @(posedge clk_i); #2 cfg_cont_i = 1'b0;
    pulse_reset();
    push(3);
`ifdef USB_SNIFFER_FLUSH_TIMEOUT_EN
    wait_b(13, 400);
    cyc(3);
    chk("f_aw_addr", aw_addr_log[12], 32'h1000);
    chk("f_aw_len", 32'(aw_len_log[12]), 32'd2);
    chk("f_current", status_current_o, 32'h100C);
    push(13);
    wait_b(14, 300);
    cyc(3);
    chk("f_aw2_addr", aw_addr_log[13], 32'h100C);
    chk("f_aw2_len", 32'(aw_len_log[13]), 32'd12);
    chk("f_current2", status_current_o, 32'h1040);
`else
    cyc(300);
    chk("t_no_aw", 32'(aw_addr_log.size()), 32'd12);
    chk("t_level", 32'(fifo_level_i), 32'd3);
    chk("t_busy", 32'(busy_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
